// File: rtl/blram_be_pipe.sv
// Single-port block RAM with per-byte write enables, valid/ready requests,
// selectable read-during-write data, optional output register and a reset clear sweep.
module blram_be_pipe #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 10,
  parameter int DEPTH        = 1024,
  parameter int RD_MODE      = 0,
  parameter int OUT_REG      = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_we,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic                o_rvalid,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_busy
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] C_LAST  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] C_ONE   = (ADDR_W+1)'(1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t            r_state, w_state_next;
  logic [ADDR_W:0]   r_clear_ptr, w_clear_ptr_next;
  logic              r_ready, r_busy;
  logic              w_clr;

  logic              w_accept, w_in_range;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [NB-1:0]     w_wr_be;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              r_v1, r_oob1;
  logic [DATA_W-1:0] r_mem_q, r_wdata1;
  logic [NB-1:0]     r_be1;
  logic [DATA_W-1:0] w_merged, w_resp;

  assign o_req_ready = r_ready;
  assign o_busy      = r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
      r_clear_ptr <= '0;
      r_ready     <= 1'b0;
      r_busy      <= (CLEAR_ON_RST != 0);
    end else begin
      r_state     <= w_state_next;
      r_clear_ptr <= w_clear_ptr_next;
      r_ready     <= (w_state_next == ST_RUN);
      r_busy      <= (w_state_next == ST_CLEAR);
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_clear_ptr_next = r_clear_ptr;
    w_clr            = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr            = 1'b1;
        w_clear_ptr_next = r_clear_ptr + C_ONE;
        if (r_clear_ptr == C_LAST) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  assign w_accept   = i_req_valid && r_ready && !rst;
  assign w_in_range = ({1'b0, i_addr} < C_DEPTH);

  // One shared write port: the clear sweep owns it while requests are blocked.
  assign w_wr_en   = !rst && (w_clr || (w_accept && i_we && w_in_range));
  assign w_wr_addr = w_clr ? r_clear_ptr[ADDR_W-1:0] : i_addr;
  assign w_wr_data = w_clr ? '0 : i_wdata;
  assign w_wr_be   = w_clr ? '1 : i_be;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (w_wr_be[b]) r_mem[w_wr_addr][8*b +: 8] <= w_wr_data[8*b +: 8];
      end
    end
  end

  // Registered read returns the pre-write word; write-first data is merged afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_oob1   <= 1'b0;
      r_mem_q  <= '0;
      r_wdata1 <= '0;
      r_be1    <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_mem_q  <= r_mem[i_addr];
        r_oob1   <= !w_in_range;
        r_wdata1 <= i_wdata;
        r_be1    <= (i_we && w_in_range) ? i_be : '0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_merge
      assign w_merged[8*gi +: 8] = ((RD_MODE != 0) && r_be1[gi]) ?
                                   r_wdata1[8*gi +: 8] : r_mem_q[8*gi +: 8];
    end
  endgenerate

  assign w_resp = r_oob1 ? '0 : w_merged;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              r_v2;
      logic [DATA_W-1:0] r_rdata2;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_v2     <= 1'b0;
          r_rdata2 <= '0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) r_rdata2 <= w_resp;
        end
      end
      assign o_rvalid = r_v2;
      assign o_rdata  = r_rdata2;
    end else begin : g_no_out_reg
      // Stage-1 registers only load on accept, so the data holds between pulses.
      assign o_rvalid = r_v1;
      assign o_rdata  = w_resp;
    end
  endgenerate

endmodule

// File: tb/tb_blram_be_pipe.sv
// Bench for blram_be_pipe: two instances (read-first/latency 1/clear, and
// write-first/latency 2/no clear/DEPTH=1000) checked against a behavioural model.
module tb_blram_be_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, vld, we, rdy, rv, busy;
  logic [3:0]  be   [2];
  logic [9:0]  addr [2];
  logic [31:0] wd   [2];
  logic [31:0] rd   [2];

  blram_be_pipe #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024), .RD_MODE(0),
                  .OUT_REG(0), .CLEAR_ON_RST(1)) u_dut0 (
    .clk(clk), .rst(rst[0]), .i_req_valid(vld[0]), .o_req_ready(rdy[0]),
    .i_we(we[0]), .i_be(be[0]), .i_addr(addr[0]), .i_wdata(wd[0]),
    .o_rvalid(rv[0]), .o_rdata(rd[0]), .o_busy(busy[0]));

  blram_be_pipe #(.DATA_W(32), .ADDR_W(10), .DEPTH(1000), .RD_MODE(1),
                  .OUT_REG(1), .CLEAR_ON_RST(0)) u_dut1 (
    .clk(clk), .rst(rst[1]), .i_req_valid(vld[1]), .o_req_ready(rdy[1]),
    .i_we(we[1]), .i_be(be[1]), .i_addr(addr[1]), .i_wdata(wd[1]),
    .o_rvalid(rv[1]), .o_rdata(rd[1]), .o_busy(busy[1]));

  typedef struct { int due; logic [31:0] data; } resp_t;

  logic [31:0] m0 [1024];
  logic [31:0] m1 [1024];
  resp_t       q0 [$];
  resp_t       q1 [$];
  logic [31:0] last [2];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h (cyc %0d)", tag, got, exp, cyc);
  endtask

  // Reference behaviour of one accepted request; returns the response word.
  task automatic model(input int d, input bit w, input logic [3:0] b,
                       input logic [9:0] a, input logic [31:0] x, output logic [31:0] r);
    int depth;
    logic [31:0] old, nw;
    depth = (d == 0) ? 1024 : 1000;
    if (int'(a) >= depth) begin
      r = '0;
    end else begin
      old = (d == 0) ? m0[a] : m1[a];
      nw  = old;
      for (int k = 0; k < 4; k++) if (b[k]) nw[8*k +: 8] = x[8*k +: 8];
      if (w) begin
        if (d == 0) m0[a] = nw; else m1[a] = nw;
      end
      r = (d == 1 && w) ? nw : old;
    end
  endtask

  // Called just after a rising edge; leaves the bench just after the accept edge.
  task automatic req(input int d, input bit w, input logic [3:0] b,
                     input logic [9:0] a, input logic [31:0] x);
    resp_t e;
    vld[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wd[d] = x;
    @(negedge clk);
    chk($sformatf("d%0d_ready", d), 32'(rdy[d]), 32'd1);
    @(posedge clk);
    #1;
    vld[d] = 1'b0;
    model(d, w, b, a, x, e.data);
    e.due = cyc + d;  // edge after which o_rvalid is visible: latency 1 + OUT_REG
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    $display("dut%0d req cyc=%0d we=%0b be=%h addr=%h wdata=%h exp=%h",
             d, cyc, w, b, a, x, e.data);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a falling edge: reset takes effect on the next rising edge.
  task automatic rst_assert(input int d);
    #1;
    rst[d] = 1'b1;
    if (d == 0) q0.delete(); else q1.delete();
    last[d] = '0;
  endtask

  task automatic mon(input int d);
    resp_t e;
    bit    exp_v;
    if (d == 0) exp_v = (q0.size() > 0) && (q0[0].due <= cyc);
    else        exp_v = (q1.size() > 0) && (q1[0].due <= cyc);
    chk($sformatf("d%0d_rvalid", d), 32'(rv[d]), 32'(exp_v));
    if (exp_v) begin
      if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
    end
    if (rv[d]) begin
      if (exp_v) chk($sformatf("d%0d_rdata", d), rd[d], e.data);
      last[d] = rd[d];
    end else begin
      chk($sformatf("d%0d_rdata_hold", d), rd[d], last[d]);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) mon(d);
    end
  end

  task automatic sweep(input int stop_at, output int k, output int nbad);
    bit done;
    k = 0; nbad = 0; done = 1'b0;
    while (!done && k < 2000) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (k == stop_at || !busy[0]) done = 1'b1;
      else if (rdy[0]) nbad++;
    end
  endtask

  initial begin
    int k, nbad;
    logic [9:0] a;
    rst = 2'b11; vld = 2'b00; we = 2'b00;
    for (int d = 0; d < 2; d++) begin
      be[d] = '0; addr[d] = '0; wd[d] = '0; last[d] = '0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_rst_ready", d), 32'(rdy[d]), 32'd0);
      chk($sformatf("d%0d_rst_rvalid", d), 32'(rv[d]), 32'd0);
      chk($sformatf("d%0d_rst_rdata", d), rd[d], 32'd0);
      chk($sformatf("d%0d_rst_busy", d), 32'(busy[d]), (d == 0) ? 32'd1 : 32'd0);
    end
    mon_en = 1'b1;

    // No-clear instance is ready on the first edge after reset falls.
    #1 rst[1] = 1'b0;
    @(negedge clk);
    chk("d1_ready_after_rst", 32'(rdy[1]), 32'd1);
    chk("d1_busy_after_rst", 32'(busy[1]), 32'd0);

    // Requests during the sweep must be ignored; reset midway restarts it.
    vld[0] = 1'b1; we[0] = 1'b0; addr[0] = 10'h155;
    #1 rst[0] = 1'b0;
    sweep(500, k, nbad);
    chk("d0_busy_mid_sweep", 32'(busy[0]), 32'd1);
    chk("d0_ready_mid_sweep", 32'(rdy[0]), 32'd0);
    rst_assert(0);
    @(posedge clk);
    @(negedge clk);
    chk("d0_busy_in_rst", 32'(busy[0]), 32'd1);
    #1 rst[0] = 1'b0;
    sweep(0, k, nbad);
    vld[0] = 1'b0;
    chk("d0_sweep_len", 32'(k), 32'd1024);
    chk("d0_ready_in_clear", 32'(nbad), 32'd0);
    chk("d0_ready_after_sweep", 32'(rdy[0]), 32'd1);
    for (int i = 0; i < 1024; i++) m0[i] = '0;
    sync();

    req(0, 1'b0, 4'h0, 10'h3FF, 32'h0);

    // Preload the uncleared instance so every later read has a known answer.
    for (int i = 0; i < 1000; i++) req(1, 1'b1, 4'hF, 10'(i), $urandom);

    for (int d = 0; d < 2; d++) begin
      req(d, 1'b1, 4'hF, 10'h010, 32'hDEADBEEF);
      req(d, 1'b1, 4'h5, 10'h010, 32'h11223344);
      req(d, 1'b0, 4'h0, 10'h010, 32'h0);
    end

    for (int i = 0; i < 400; i++) begin
      a = ($urandom % 2 != 0) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(1008, 1023));
      req(0, 1'($urandom), 4'($urandom), a, $urandom);
      a = ($urandom % 2 != 0) ? 10'($urandom_range(0, 7)) : 10'($urandom_range(990, 1023));
      req(1, 1'($urandom), 4'($urandom), a, $urandom);
    end

    req(1, 1'b1, 4'hF, 10'd1, 32'hA);
    req(1, 1'b1, 4'hF, 10'd2, 32'hB);
    req(1, 1'b1, 4'hF, 10'd3, 32'hC);
    req(1, 1'b0, 4'h0, 10'd1, 32'h0);
    req(1, 1'b0, 4'h0, 10'd2, 32'h0);
    req(1, 1'b0, 4'h0, 10'd3, 32'h0);

    req(1, 1'b1, 4'hF, 10'd1000, 32'h5555AAAA);
    req(1, 1'b0, 4'h0, 10'd1000, 32'h0);
    req(1, 1'b1, 4'h0, 10'd5, 32'hFFFFFFFF);
    req(1, 1'b0, 4'h0, 10'd5, 32'h0);

    // Contents survive reset without clear; in-flight and reset-cycle reads vanish.
    req(1, 1'b1, 4'hF, 10'd7, 32'h12345678);
    repeat (4) sync();
    req(1, 1'b0, 4'h0, 10'd7, 32'h0);
    @(negedge clk);
    rst_assert(1);
    vld[1] = 1'b1; we[1] = 1'b0; addr[1] = 10'd7;
    chk("d1_ready_at_rst_edge", 32'(rdy[1]), 32'd1);
    @(posedge clk);
    #1 vld[1] = 1'b0;
    @(negedge clk);
    #1 rst[1] = 1'b0;
    @(negedge clk);
    chk("d1_ready_first_edge", 32'(rdy[1]), 32'd1);
    sync();
    req(1, 1'b0, 4'h0, 10'd7, 32'h0);

    for (int i = 0; i < 1024; i++) begin
      req(0, 1'b0, 4'h0, 10'(i), 32'h0);
      req(1, 1'b0, 4'h0, 10'(i), 32'h0);
    end
    repeat (6) sync();
    chk("d0_queue_drained", 32'(q0.size()), 32'd0);
    chk("d1_queue_drained", 32'(q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/blram_be_pipe.md
Name: blram_be_pipe

Overview:
Parametrised single-port block RAM, successor to the fixed 32x1024 program/data RAM. Adds configurable data width and depth, per-byte write enables, a valid/ready request handshake, selectable read-during-write mode, an optional output register and a reset-triggered clear sweep. It sits between the core's load/store unit (or instruction fetch) and on-chip storage.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8.
ADDR_W, 10, address width in words.
DEPTH, 1024, number of words; must satisfy DEPTH <= 2**ADDR_W.
RD_MODE, 0, read-during-write data: 0 = read-first (old word), 1 = write-first (merged new word).
OUT_REG, 0, extra output pipeline stage: 0 = read latency 1, 1 = read latency 2.
CLEAR_ON_RST, 1, 1 = zero every word after reset; 0 = no clear, contents retained.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
i_req_valid  input  1  request present.
o_req_ready  output  1  block can accept a request this cycle.
i_we  input  1  1 = write request, 0 = read request.
i_be  input  DATA_W/8  byte write enables; bit k covers i_wdata[8k+7:8k].
i_addr  input  ADDR_W  word address.
i_wdata  input  DATA_W  write data.
o_rvalid  output  1  o_rdata is valid this cycle.
o_rdata  output  DATA_W  response data.
o_busy  output  1  clear sweep in progress.

Behaviour:
- Accept: a request is accepted on a rising edge where i_req_valid && o_req_ready. Without backpressure, one request per cycle.
- Reset (synchronous, any state):
  - state <= CLEAR if CLEAR_ON_RST, else RUN.
  - clear_ptr <= 0.
  - o_req_ready <= 0, o_rvalid <= 0, o_rdata <= 0, all pipeline valids <= 0.
  - o_busy <= CLEAR_ON_RST.
  - Memory is not touched by rst itself.
- State CLEAR:
  - Each cycle writes 0 to memory[clear_ptr], then clear_ptr++.
  - o_req_ready = 0 and o_busy = 1 throughout; requests are ignored, not queued.
  - After writing word DEPTH-1, go to RUN. o_busy falls and o_req_ready rises together on that edge.
  - Total: DEPTH cycles after the rst-deasserted edge.
- State RUN (CLEAR_ON_RST=0 enters it on the first edge without rst):
  - o_req_ready = 1 and o_busy = 0.
- Every accepted request (read or write) produces exactly one response, in order:
  - o_rvalid is a one-cycle pulse 1+OUT_REG edges after acceptance.
  - o_rvalid is low in all other cycles.
- Read response: o_rdata = memory[i_addr] as of the accept edge.
- Write:
  - Updates only the bytes whose i_be bit is 1.
  - i_we=1 with i_be=0 is a no-op write that still returns a response.
  - Response data: RD_MODE=0 returns the old word; RD_MODE=1 returns the merged word (old bytes where be=0, new bytes where be=1).
- Back-to-back requests to the same address: the second request sees the first write (memory is updated at the accept edge).
- Out-of-range address (i_addr >= DEPTH): write is discarded; response data is 0; o_rvalid still pulses.
- o_rdata holds its last value when o_rvalid is low. It resets to 0.
- Reset mid-operation:
  - In-flight responses are dropped (no o_rvalid).
  - Reset during CLEAR restarts the sweep at address 0.
- Widths: clear_ptr has ADDR_W+1 bits so it reaches DEPTH without wrap. No other arithmetic.

Test Plan:
1. Defaults (DATA_W=32, DEPTH=1024, CLEAR_ON_RST=1): pulse rst 1 cycle -> o_busy=1, o_req_ready=0 for exactly 1024 cycles. Then read addr 0x3FF -> o_rvalid 1 cycle later, o_rdata=0x00000000.
2. Write 0xDEADBEEF, be=4'b1111 @0x010. Then write 0x11223344, be=4'b0101 @0x010. Then read 0x010 -> read returns 0xDE22BE44. Second write's response: RD_MODE=0 gives 0xDEADBEEF; RD_MODE=1 gives 0xDE22BE44.
3. OUT_REG=1: three consecutive accepted reads @1,2,3 (preloaded 0xA,0xB,0xC) -> o_rvalid high on edges acc+2..acc+4 with 0xA,0xB,0xC in order, no gaps.
4. DEPTH=1000, ADDR_W=10: write 0x5555AAAA @1000, then read @1000 -> response 0; words 0..999 unchanged. Write with be=0 @5 -> word 5 unchanged, o_rvalid still pulses.
5. Assert rst at clear_ptr=500; issue i_req_valid during CLEAR -> o_req_ready stays 0, no o_rvalid; sweep restarts and busy lasts 1024 cycles from the reset release.
6. CLEAR_ON_RST=0: write 0x12345678 @7; pulse rst; read @7 -> 0x12345678. o_req_ready=1 on the first edge after rst falls. A read accepted on the cycle rst asserts produces no response.
